// File: rtl/inst_fetch.sv
// inst_fetch: single-outstanding instruction fetch feeding decode through a pc-tagged FIFO.
// Define FETCH_TIMEOUT_EN to add an imem_ack watchdog with a sticky fetch_err.

module inst_fetch #(
    parameter int unsigned IMEM_AW     = 10,
    parameter int unsigned DEPTH       = 2,
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [31:0]        pc,
    input  logic               halt,
    input  logic               flush,
    output logic               imem_req,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic               imem_ack,
    input  logic [31:0]        imem_rdata,
    output logic               instr_valid,
    output logic [31:0]        instr,
    output logic [31:0]        instr_pc,
    input  logic               dec_ready,
    output logic               pc_step,
    output logic               fetch_err
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StHalt,
        StErr
    } state_e;

    state_e             state_q, state_d;
    logic               req_q, req_d;
    logic [IMEM_AW-1:0] addr_q, addr_d;
    logic [31:0]        pc_lat_q, pc_lat_d;
    logic               drop_q, drop_d;
    logic               step_q;

    logic [31:0]        fifo_instr_q [DEPTH];
    logic [31:0]        fifo_pc_q    [DEPTH];
    logic [PtrW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]    count_q;

    logic               push;
    logic               pop;
    logic               full;
    logic               empty;

`ifdef FETCH_TIMEOUT_EN
    localparam int unsigned TmoW = $clog2(TIMEOUT_CYC + 1);
    logic [TmoW-1:0]    tmo_q, tmo_d;
    logic               err_q, err_d;
`endif

    assign full  = (count_q == CntW'(DEPTH));
    assign empty = (count_q == '0);
    // Flush wins over a pop in the same cycle.
    assign pop   = !empty && dec_ready && !flush;

    always_comb begin
        state_d  = state_q;
        req_d    = req_q;
        addr_d   = addr_q;
        pc_lat_d = pc_lat_q;
        drop_d   = drop_q;
        push     = 1'b0;
`ifdef FETCH_TIMEOUT_EN
        tmo_d    = '0;
        err_d    = err_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (halt) begin
                    state_d = StHalt;
                end else if (!full && !flush) begin
                    req_d    = 1'b1;
                    addr_d   = pc[IMEM_AW+1:2];
                    pc_lat_d = pc;
                    state_d  = StWait;
                end
            end
            StWait: begin
                if (imem_ack) begin
                    req_d  = 1'b0;
                    drop_d = 1'b0;
                    if (drop_q) begin
                        state_d = StIdle;
                    end else begin
                        // A flush landing on the ack cycle discards the returning word.
                        push    = !flush;
                        state_d = halt ? StHalt : StIdle;
                    end
                end else if (flush) begin
                    drop_d = 1'b1;
                end
`ifdef FETCH_TIMEOUT_EN
                else if (tmo_q == TmoW'(TIMEOUT_CYC - 1)) begin
                    req_d   = 1'b0;
                    err_d   = 1'b1;
                    state_d = StErr;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
`endif
            end
            StHalt: begin
                if (!halt) begin
                    state_d = StIdle;
                end
            end
            StErr: begin
                req_d = 1'b0;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StIdle;
            req_q    <= 1'b0;
            addr_q   <= '0;
            pc_lat_q <= '0;
            drop_q   <= 1'b0;
            step_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            req_q    <= req_d;
            addr_q   <= addr_d;
            pc_lat_q <= pc_lat_d;
            drop_q   <= drop_d;
            step_q   <= push;
        end
    end

`ifdef FETCH_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tmo_q <= '0;
            err_q <= 1'b0;
        end else begin
            tmo_q <= tmo_d;
            err_q <= err_d;
        end
    end

    assign fetch_err = err_q;
`else
    assign fetch_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CntW'(1);
                2'b01:   count_q <= count_q - CntW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                fifo_instr_q[i] <= '0;
                fifo_pc_q[i]    <= '0;
            end
        end else if (push) begin
            fifo_instr_q[wr_ptr_q] <= imem_rdata;
            fifo_pc_q[wr_ptr_q]    <= pc_lat_q;
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = addr_q;
    assign instr_valid = !empty;
    assign instr       = fifo_instr_q[rd_ptr_q];
    assign instr_pc    = fifo_pc_q[rd_ptr_q];
    assign pc_step     = step_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: queue-based fetch model checked every cycle, plus directed scenarios.
// The timeout scenario runs only when FETCH_TIMEOUT_EN is defined.

module tb_inst_fetch;

    localparam int unsigned IMEM_AW = 10;
    localparam int unsigned DEPTH   = 2;

    logic               clk;
    logic               rst;
    logic [31:0]        pc;
    logic               halt;
    logic               flush;
    logic               imem_req;
    logic [IMEM_AW-1:0] imem_addr;
    logic               imem_ack;
    logic [31:0]        imem_rdata;
    logic               instr_valid;
    logic [31:0]        instr;
    logic [31:0]        instr_pc;
    logic               dec_ready;
    logic               pc_step;
    logic               fetch_err;

    inst_fetch #(
        .IMEM_AW    (IMEM_AW),
        .DEPTH      (DEPTH),
        .TIMEOUT_CYC(16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pc         (pc),
        .halt       (halt),
        .flush      (flush),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .instr_valid(instr_valid),
        .instr      (instr),
        .instr_pc   (instr_pc),
        .dec_ready  (dec_ready),
        .pc_step    (pc_step),
        .fetch_err  (fetch_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] w;
    } ent_t;

    int   vectors     = 0;
    int   miscompares = 0;
    int   ack_lat     = 1;
    int   step_cnt    = 0;
    logic tmo_phase   = 1'b0;
    ent_t log_q[$];

    function automatic logic [31:0] word_of(input logic [IMEM_AW-1:0] a);
        return 32'hC0DE_0000 | {22'd0, a};
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Instruction memory: acks ack_lat cycles after req is seen, data derived from the address.
    initial begin : imem
        int             wcnt;
        logic           nack;
        logic [IMEM_AW-1:0] raddr;
        imem_ack   = 1'b0;
        imem_rdata = '0;
        wcnt       = 0;
        forever begin
            @(posedge clk);
            nack  = 1'b0;
            raddr = imem_addr;
            if (!rst || imem_ack || !imem_req) begin
                wcnt = 0;
            end else begin
                wcnt++;
                nack = (wcnt >= ack_lat);
            end
            #1;
            imem_ack   = nack;
            imem_rdata = nack ? word_of(raddr) : 32'h0;
        end
    end

    // Fetch model: one outstanding fetch, FIFO as a queue, flush drops buffered and in-flight words.
    initial begin : model
        ent_t        q[$];
        ent_t        new_e;
        logic        outstanding;
        logic        dropped;
        logic        exp_step;
        logic        step_next;
        logic        push_en;
        logic [31:0] out_pc;
        logic [31:0] prev_pc;
        logic        prev_flush;
        logic        prev_halt;
        int          prev_count;
        int          cur_count;
        outstanding = 1'b0;
        dropped     = 1'b0;
        exp_step    = 1'b0;
        out_pc      = '0;
        prev_pc     = '0;
        prev_flush  = 1'b0;
        prev_halt   = 1'b0;
        prev_count  = 0;
        forever begin
            @(posedge clk);
            if (!rst) begin
                q.delete();
                outstanding = 1'b0;
                dropped     = 1'b0;
                exp_step    = 1'b0;
                prev_pc     = '0;
                prev_flush  = 1'b0;
                prev_halt   = 1'b0;
                prev_count  = 0;
            end else begin
                step_next = 1'b0;
                push_en   = 1'b0;
                new_e     = '0;
                cur_count = q.size();
                if (pc_step) step_cnt++;
                if (instr_valid && dec_ready && !flush) log_q.push_back('{instr_pc, instr});
                if (outstanding && !imem_req) begin
                    if (!tmo_phase) check("req held until ack", {31'd0, imem_req}, 32'd1);
                    outstanding = 1'b0;
                end else if (imem_req && !outstanding) begin
                    // A new request must follow an idle cycle that saw no flush, no halt, room.
                    check("req legal {flush,halt,room}",
                          {29'd0, prev_flush, prev_halt, prev_count < DEPTH}, 32'd1);
                    check("req imem_addr", {22'd0, imem_addr}, {22'd0, prev_pc[11:2]});
                    outstanding = 1'b1;
                    out_pc      = prev_pc;
                    dropped     = 1'b0;
                end else if (outstanding) begin
                    check("imem_addr stable", {22'd0, imem_addr}, {22'd0, out_pc[11:2]});
                end
                if (outstanding && imem_ack) begin
                    if (!flush && !dropped) begin
                        push_en   = 1'b1;
                        new_e     = '{out_pc, word_of(out_pc[11:2])};
                        step_next = 1'b1;
                    end
                    outstanding = 1'b0;
                end else if (outstanding && flush) begin
                    dropped = 1'b1;
                end
                if (flush) begin
                    q.delete();
                end else begin
                    if (q.size() > 0 && dec_ready) void'(q.pop_front());
                    if (push_en) q.push_back(new_e);
                end
                exp_step   = step_next;
                prev_pc    = pc;
                prev_flush = flush;
                prev_halt  = halt;
                prev_count = cur_count;
            end
            @(negedge clk);
            if (!rst) begin
                check("rst imem_req", {31'd0, imem_req}, 32'd0);
                check("rst instr_valid", {31'd0, instr_valid}, 32'd0);
                check("rst pc_step", {31'd0, pc_step}, 32'd0);
                check("rst fetch_err", {31'd0, fetch_err}, 32'd0);
            end else begin
                check("instr_valid", {31'd0, instr_valid}, {31'd0, q.size() != 0});
                if (q.size() != 0) begin
                    check("instr_pc", instr_pc, q[0].pc);
                    check("instr", instr, q[0].w);
                end
                check("pc_step", {31'd0, pc_step}, {31'd0, exp_step});
                if (!tmo_phase) check("fetch_err", {31'd0, fetch_err}, 32'd0);
            end
        end
    end

    task automatic wait_req(input string nm);
        int n;
        n = 0;
        @(negedge clk);
        while (!imem_req && n < 60) begin
            @(negedge clk);
            n++;
        end
        check(nm, {31'd0, imem_req}, 32'd1);
    endtask

    // Returns just after the posedge at which the DUT sampled an ack.
    task automatic wait_ack(input string nm);
        int   n;
        logic seen;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 60) begin
            @(posedge clk);
            seen = imem_req && imem_ack;
            n++;
        end
        check(nm, {31'd0, seen}, 32'd1);
    endtask

    task automatic check_log(input string nm, input int idx, input logic [31:0] epc,
                             input logic [31:0] ew);
        if (idx < log_q.size()) begin
            check({nm, " pc"}, log_q[idx].pc, epc);
            check({nm, " instr"}, log_q[idx].w, ew);
        end else begin
            check({nm, " present"}, 32'd0, 32'd1);
        end
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int   sbase;
        int   lbase;
        int   n;
        logic flag;
        rst       = 1'b0;
        pc        = 32'h40;
        halt      = 1'b0;
        flush     = 1'b0;
        dec_ready = 1'b1;
        ack_lat   = 50;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;

        // Reset while a request is outstanding.
        wait_req("T1 req issued");
        #2 rst = 1'b0;
        #1;
        check("T1 imem_req", {31'd0, imem_req}, 32'd0);
        check("T1 imem_addr", {22'd0, imem_addr}, 32'd0);
        check("T1 instr_valid", {31'd0, instr_valid}, 32'd0);
        check("T1 instr", instr, 32'd0);
        check("T1 instr_pc", instr_pc, 32'd0);
        check("T1 pc_step", {31'd0, pc_step}, 32'd0);
        check("T1 fetch_err", {31'd0, fetch_err}, 32'd0);
        ack_lat = 1;
        pc      = 32'h44;
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        wait_req("T1 req after reset");
        check("T1 first addr", {22'd0, imem_addr}, 32'h011);
        wait_ack("T1 ack");
        #1 halt = 1'b1;
        repeat (4) @(negedge clk);

        // Streaming pc=0,4,8.
        sbase = step_cnt;
        lbase = log_q.size();
        pc    = 32'h0;
        halt  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            wait_ack("T2 ack");
            #1 pc = pc + 32'd4;
        end
        halt = 1'b1;
        repeat (4) @(negedge clk);
        check("T2 pc_step pulses", step_cnt - sbase, 32'd3);
        check_log("T2 word0", lbase,     32'h0, 32'hC0DE_0000);
        check_log("T2 word1", lbase + 1, 32'h4, 32'hC0DE_0001);
        check_log("T2 word2", lbase + 2, 32'h8, 32'hC0DE_0002);

        // FIFO full with decode stalled.
        sbase     = step_cnt;
        lbase     = log_q.size();
        dec_ready = 1'b0;
        pc        = 32'h100;
        halt      = 1'b0;
        for (int i = 0; i < 2; i++) begin
            wait_ack("T3 ack");
            #1 pc = pc + 32'd4;
        end
        flag = 1'b0;
        repeat (10) begin
            @(negedge clk);
            flag = flag | imem_req;
        end
        check("T3 no req while full", {31'd0, flag}, 32'd0);
        check("T3 pc_step pulses", step_cnt - sbase, 32'd2);
        check("T3 head valid", {31'd0, instr_valid}, 32'd1);
        check("T3 head pc", instr_pc, 32'h100);
        dec_ready = 1'b1;
        wait_ack("T3 resume ack");
        #1 pc = pc + 32'd4;
        halt = 1'b1;
        repeat (4) @(negedge clk);
        check_log("T3 word0", lbase,     32'h100, 32'hC0DE_0040);
        check_log("T3 word1", lbase + 1, 32'h104, 32'hC0DE_0041);
        check_log("T3 word2", lbase + 2, 32'h108, 32'hC0DE_0042);

        // Flush while waiting; the late ack must be dropped.
        ack_lat = 3;
        pc      = 32'h10;
        halt    = 1'b0;
        sbase   = step_cnt;
        wait_req("T4 req issued");
        flush = 1'b1;
        pc    = 32'h3c0;
        @(negedge clk);
        flush = 1'b0;
        n = 0;
        while (imem_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        wait_req("T4 redirected req");
        check("T4 redirected addr", {22'd0, imem_addr}, 32'h0F0);
        check("T4 no pc_step for dropped word", step_cnt - sbase, 32'd0);
        wait_ack("T4 ack");
        #1 halt = 1'b1;
        repeat (4) @(negedge clk);
        check("T4 pc_step pulses", step_cnt - sbase, 32'd1);
        check_log("T4 word", log_q.size() - 1, 32'h3c0, 32'hC0DE_00F0);

        // Halt raised with a request outstanding.
        ack_lat = 2;
        pc      = 32'h20;
        halt    = 1'b0;
        sbase   = step_cnt;
        wait_req("T5 req issued");
        halt = 1'b1;
        wait_ack("T5 ack");
        #1 pc = 32'h24;
        flag = 1'b0;
        repeat (8) begin
            @(negedge clk);
            flag = flag | imem_req;
        end
        check("T5 no req while halted", {31'd0, flag}, 32'd0);
        check("T5 pc_step pulses", step_cnt - sbase, 32'd1);
        check_log("T5 word", log_q.size() - 1, 32'h20, 32'hC0DE_0008);
        halt = 1'b0;
        wait_req("T5 req after halt");
        check("T5 addr after halt", {22'd0, imem_addr}, 32'h009);
        wait_ack("T5 ack2");
        #1 halt = 1'b1;
        repeat (4) @(negedge clk);

`ifdef FETCH_TIMEOUT_EN
        // Ack never arrives: 16 cycles of req, then sticky error.
        tmo_phase = 1'b1;
        ack_lat   = 100000;
        pc        = 32'h80;
        halt      = 1'b0;
        wait_req("T6 req issued");
        n = 1;
        @(negedge clk);
        while (imem_req && n < 40) begin
            n++;
            @(negedge clk);
        end
        check("T6 cycles in WAIT", n, 32'd16);
        check("T6 fetch_err", {31'd0, fetch_err}, 32'd1);
        flag = 1'b0;
        repeat (5) begin
            @(negedge clk);
            flag = flag | imem_req | !fetch_err;
        end
        check("T6 err sticky, req low", {31'd0, flag}, 32'd0);
        #2 rst = 1'b0;
        #1 check("T6 err cleared by reset", {31'd0, fetch_err}, 32'd0);
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        tmo_phase = 1'b0;
        ack_lat   = 1;
        repeat (4) @(negedge clk);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
